// File: rtl/local_ctrl_fc_gen.sv
// -----------------------------------------------------------------------------
// local_ctrl_fc_gen
//
// Local controller for one fully-connected layer of the streaming MNIST
// datapath. Runs NUM_PASS output-group passes of IN_LEN MACs each over one
// input vector, driving buffer reads, MAC enable/clear, a delayed ReLU pulse
// and a one-hot temp-buffer write strobe per pass.
//
// Optional build macro: LOCAL_CTRL_FC_GEN_RESTART_EN
//   defined   - DONE accepts start_i exactly like IDLE (batch restart).
//   undefined - DONE is terminal until rstn_i.
//
// Ports:
//   clk_i         clock
//   rstn_i        asynchronous active-low reset
//   start_i       frame start, sampled in IDLE only
//   cnt_i         global frame counter (LAST_CNT marks the final frame)
//   x_addr_o      activation read address
//   x_en_o        activation read enable
//   w_addr_o      weight read address
//   w_en_o        weight read enable
//   mac_en_o      MAC accumulate enable (read enable delayed by 1)
//   mac_clear_o   accumulator clear on first MAC of a pass
//   relu_en_o     ReLU enable pulse
//   temp_wr_en_o  one-hot temp-buffer write strobe, bit p for pass p
//   pass_o        current pass index
//   busy_o        high in RUN, SAVE and NEXT
//   frame_done_o  one-cycle pulse at end of every frame
//   done_o        one-cycle pulse when the final frame completes
// -----------------------------------------------------------------------------
module local_ctrl_fc_gen #(
    parameter int IN_LEN   = 64,
    parameter int NUM_PASS = 2,
    parameter int X_AW     = 6,
    parameter int W_AW     = 7,
    parameter int RELU_LAT = 2,
    parameter int WR_LAT   = 3,
    parameter int SAVE_CYC = 4,
    parameter int CNT_W    = 13,
    parameter int LAST_CNT = 7879,
    localparam int PASS_W  = (NUM_PASS > 1) ? $clog2(NUM_PASS) : 1
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic                start_i,
    input  logic [CNT_W-1:0]    cnt_i,
    output logic [X_AW-1:0]     x_addr_o,
    output logic                x_en_o,
    output logic [W_AW-1:0]     w_addr_o,
    output logic                w_en_o,
    output logic                mac_en_o,
    output logic                mac_clear_o,
    output logic                relu_en_o,
    output logic [NUM_PASS-1:0] temp_wr_en_o,
    output logic [PASS_W-1:0]   pass_o,
    output logic                busy_o,
    output logic                frame_done_o,
    output logic                done_o
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RUN  = 3'd1;
    localparam logic [2:0] S_SAVE = 3'd2;
    localparam logic [2:0] S_NEXT = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam int SC_W = $clog2(SAVE_CYC);

`ifdef LOCAL_CTRL_FC_GEN_RESTART_EN
    localparam bit RESTART = 1'b1;
`else
    localparam bit RESTART = 1'b0;
`endif

    logic [2:0]          state_q;
    logic [X_AW-1:0]     rd_cnt_q;    // index of the next read within the pass
    logic                rd_done_q;   // all IN_LEN reads of this pass issued
    logic                last_rd_q;   // pulses alongside the final read
    logic [SC_W-1:0]     save_cnt_q;
    logic [W_AW-1:0]     w_base_q;    // pass * IN_LEN, kept incrementally
    logic [SAVE_CYC-1:0] lat_sr_q;    // bit j set j cycles after the last MAC
    logic [NUM_PASS-1:0] pass_onehot;

    assign pass_onehot = NUM_PASS'(1) << pass_o;

    // Sequencer: state, pass, read addresses and frame-level pulses.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values and block ordering cannot matter.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q      <= S_IDLE;
            pass_o       <= '0;
            rd_cnt_q     <= '0;
            rd_done_q    <= 1'b0;
            last_rd_q    <= 1'b0;
            save_cnt_q   <= '0;
            w_base_q     <= '0;
            x_addr_o     <= '0;
            x_en_o       <= 1'b0;
            w_addr_o     <= '0;
            w_en_o       <= 1'b0;
            busy_o       <= 1'b0;
            frame_done_o <= 1'b0;
            done_o       <= 1'b0;
        end else begin
            last_rd_q    <= 1'b0;
            frame_done_o <= 1'b0;
            done_o       <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_i && (state_q == S_IDLE || RESTART)) begin
                        state_q   <= S_RUN;
                        pass_o    <= '0;
                        w_base_q  <= '0;
                        rd_cnt_q  <= '0;
                        rd_done_q <= 1'b0;
                        busy_o    <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (!rd_done_q) begin
                        x_en_o   <= 1'b1;
                        w_en_o   <= 1'b1;
                        x_addr_o <= rd_cnt_q;
                        w_addr_o <= w_base_q + W_AW'(rd_cnt_q);
                        if (rd_cnt_q == X_AW'(IN_LEN - 1)) begin
                            rd_done_q <= 1'b1;
                            last_rd_q <= 1'b1;
                        end else begin
                            rd_cnt_q <= rd_cnt_q + X_AW'(1);
                        end
                    end else begin
                        // Addresses hold; this edge carries the last MAC.
                        x_en_o     <= 1'b0;
                        w_en_o     <= 1'b0;
                        save_cnt_q <= '0;
                        state_q    <= S_SAVE;
                    end
                end
                S_SAVE: begin
                    if (save_cnt_q == SC_W'(SAVE_CYC - 1)) begin
                        if (pass_o != PASS_W'(NUM_PASS - 1)) begin
                            pass_o    <= pass_o + PASS_W'(1);
                            w_base_q  <= w_base_q + W_AW'(IN_LEN);
                            rd_cnt_q  <= '0;
                            rd_done_q <= 1'b0;
                            state_q   <= S_RUN;
                        end else begin
                            state_q <= S_NEXT;
                        end
                    end else begin
                        save_cnt_q <= save_cnt_q + SC_W'(1);
                    end
                end
                S_NEXT: begin
                    frame_done_o <= 1'b1;
                    busy_o       <= 1'b0;
                    if (cnt_i == CNT_W'(LAST_CNT)) begin
                        done_o  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Delay lines run every cycle independent of state, so a launched
    // ReLU or write pulse always completes. The pass index is still valid
    // at the write pulse because it only advances at the end of SAVE.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            mac_en_o     <= 1'b0;
            mac_clear_o  <= 1'b0;
            lat_sr_q     <= '0;
            relu_en_o    <= 1'b0;
            temp_wr_en_o <= '0;
        end else begin
            mac_en_o     <= x_en_o;
            // First read of a pass: enable present but MAC not yet running.
            mac_clear_o  <= x_en_o & ~mac_en_o;
            lat_sr_q     <= {lat_sr_q[SAVE_CYC-2:0], last_rd_q};
            relu_en_o    <= lat_sr_q[RELU_LAT-1];
            temp_wr_en_o <= lat_sr_q[WR_LAT-1] ? pass_onehot : '0;
        end
    end

endmodule

// File: tb/tb_local_ctrl_fc_gen.sv
// -----------------------------------------------------------------------------
// tb_local_ctrl_fc_gen
//
// Cycle-accurate scoreboard bench. Two instances: the default configuration
// (dut_a) and a reparametrised one with NUM_PASS=4, IN_LEN=16, W_AW=6 (dut_b).
// Each frame pushes one expected output vector per cycle, derived from the
// timing model of the controller; the vectors are popped and compared one
// cycle at a time, 1 ns after each rising edge.
// -----------------------------------------------------------------------------
module tb_local_ctrl_fc_gen;

    localparam int          SAVE_CYC = 4;
    localparam int          RELU_LAT = 2;
    localparam int          WR_LAT   = 3;
    localparam logic [12:0] LAST     = 13'd7879;

    typedef struct packed {
        logic       x_en;
        logic       w_en;
        logic       mac_en;
        logic       mac_clr;
        logic       relu;
        logic [3:0] twr;
        logic [1:0] pass;
        logic       busy;
        logic       fdone;
        logic       done;
        logic [5:0] xa;
        logic [6:0] wa;
    } out_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start_a = 1'b0;
    logic        start_b = 1'b0;
    logic [12:0] cnt = '0;

    logic [5:0] a_xa;  logic a_xen;  logic [6:0] a_wa;  logic a_wen;
    logic a_mac;  logic a_clr;  logic a_relu;  logic [1:0] a_twr;
    logic [0:0] a_pass;  logic a_busy;  logic a_fdone;  logic a_done;

    logic [5:0] b_xa;  logic b_xen;  logic [5:0] b_wa;  logic b_wen;
    logic b_mac;  logic b_clr;  logic b_relu;  logic [3:0] b_twr;
    logic [1:0] b_pass;  logic b_busy;  logic b_fdone;  logic b_done;

    always #5 clk = ~clk;

    local_ctrl_fc_gen dut_a (
        .clk_i(clk), .rstn_i(rstn), .start_i(start_a), .cnt_i(cnt),
        .x_addr_o(a_xa), .x_en_o(a_xen), .w_addr_o(a_wa), .w_en_o(a_wen),
        .mac_en_o(a_mac), .mac_clear_o(a_clr), .relu_en_o(a_relu),
        .temp_wr_en_o(a_twr), .pass_o(a_pass), .busy_o(a_busy),
        .frame_done_o(a_fdone), .done_o(a_done)
    );

    local_ctrl_fc_gen #(.IN_LEN(16), .NUM_PASS(4), .W_AW(6)) dut_b (
        .clk_i(clk), .rstn_i(rstn), .start_i(start_b), .cnt_i(cnt),
        .x_addr_o(b_xa), .x_en_o(b_xen), .w_addr_o(b_wa), .w_en_o(b_wen),
        .mac_en_o(b_mac), .mac_clear_o(b_clr), .relu_en_o(b_relu),
        .temp_wr_en_o(b_twr), .pass_o(b_pass), .busy_o(b_busy),
        .frame_done_o(b_fdone), .done_o(b_done)
    );

    int   total = 0;
    int   bad = 0;
    out_t exp_q[$];
    out_t hold[2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic out_t sample(input int sel);
        out_t s = '0;
        if (sel == 0) begin
            s.x_en = a_xen;  s.w_en = a_wen;  s.mac_en = a_mac;  s.mac_clr = a_clr;
            s.relu = a_relu; s.twr = {2'b00, a_twr}; s.pass = {1'b0, a_pass};
            s.busy = a_busy; s.fdone = a_fdone; s.done = a_done;
            s.xa = a_xa;     s.wa = a_wa;
        end else begin
            s.x_en = b_xen;  s.w_en = b_wen;  s.mac_en = b_mac;  s.mac_clr = b_clr;
            s.relu = b_relu; s.twr = b_twr;   s.pass = b_pass;
            s.busy = b_busy; s.fdone = b_fdone; s.done = b_done;
            s.xa = b_xa;     s.wa = {1'b0, b_wa};
        end
        return s;
    endfunction

    // Expected outputs t cycles after the start edge, given the values held
    // from before the frame (h).
    function automatic out_t model(input int t, input int il, input int np,
                                   input logic [12:0] c, input out_t h);
        out_t e = '0;
        int   per = il + SAVE_CYC + 1;
        int   f = np * per + 1;
        e.xa = h.xa;
        e.wa = h.wa;
        for (int p = 0; p < np; p++) begin
            int s = 1 + p * per;
            int l = s + il;
            int k;
            if (t >= s - 1) e.pass = 2'(p);
            if (t >= s) begin
                k = (t - s < il - 1) ? t - s : il - 1;
                e.xa = 6'(k);
                e.wa = 7'(p * il + k);
            end
            if (t >= s && t < s + il) begin
                e.x_en = 1'b1;
                e.w_en = 1'b1;
            end
            if (t > s && t <= l) e.mac_en = 1'b1;
            if (t == s + 1) e.mac_clr = 1'b1;
            if (t == l + RELU_LAT) e.relu = 1'b1;
            if (t == l + WR_LAT) e.twr[p] = 1'b1;
        end
        e.busy  = (t < f);
        e.fdone = (t == f);
        e.done  = (t == f) && (c == LAST);
        return e;
    endfunction

    task automatic push_frame(input int sel, input logic [12:0] c);
        int il = (sel == 0) ? 64 : 16;
        int np = (sel == 0) ? 2 : 4;
        int f  = np * (il + SAVE_CYC + 1) + 1;
        for (int t = 0; t <= f + 2; t++) exp_q.push_back(model(t, il, np, c, hold[sel]));
        hold[sel] = model(f + 2, il, np, c, hold[sel]);
    endtask

    task automatic start_frame(input int sel, input logic [12:0] c);
        @(negedge clk);
        cnt = c;
        if (sel == 0) start_a = 1'b1;
        else          start_b = 1'b1;
    endtask

    task automatic drain(input int sel);
        int   t = 0;
        out_t e;
        while (exp_q.size() > 0) begin
            @(posedge clk);
            #1;
            start_a = 1'b0;
            start_b = 1'b0;
            e = exp_q.pop_front();
            check($sformatf("dut%0d t=%0d", sel, t), {5'd0, sample(sel)}, {5'd0, e});
            t++;
        end
    endtask

    initial begin
        out_t e;
        hold[0] = '0;
        hold[1] = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("reset_a", {5'd0, sample(0)}, 32'd0);
        check("reset_b", {5'd0, sample(1)}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        // Reset in the middle of a pass: outputs clear without a clock edge
        start_frame(0, 13'd5);
        push_frame(0, 13'd5);
        for (int i = 0; i <= 30; i++) begin
            @(posedge clk);
            #1;
            start_a = 1'b0;
            e = exp_q.pop_front();
            check($sformatf("pre_rst t=%0d", i), {5'd0, sample(0)}, {5'd0, e});
        end
        #2 rstn = 1'b0;
        #1;
        check("async_rst_a", {5'd0, sample(0)}, 32'd0);
        check("async_rst_b", {5'd0, sample(1)}, 32'd0);
        exp_q.delete();
        hold[0] = '0;
        @(negedge clk);
        rstn = 1'b1;
        repeat (4) exp_q.push_back(hold[0]);
        drain(0);

        // Full two-pass frame, not the final one
        start_frame(0, 13'd5);
        push_frame(0, 13'd5);
        drain(0);

        // Final frame: done pulses with frame_done
        start_frame(0, LAST);
        push_frame(0, LAST);
        drain(0);

        // Start after the final frame
        start_frame(0, 13'd5);
`ifdef LOCAL_CTRL_FC_GEN_RESTART_EN
        push_frame(0, 13'd5);
`else
        repeat (20) exp_q.push_back(hold[0]);
`endif
        drain(0);

        // Reparametrised instance: four passes of sixteen
        start_frame(1, 13'd5);
        push_frame(1, 13'd5);
        drain(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/local_ctrl_fc_gen.md
Name: local_ctrl_fc_gen

Overview:
Parametrised local controller for one fully-connected layer in the streaming MNIST datapath.
- Sequences NUM_PASS output-group passes of IN_LEN MACs each, from one input vector.
- Drives weight/activation buffer reads, MAC enable and clear, delayed ReLU enable, and a one-hot temp-buffer write strobe per pass.
- Sits between the global frame counter (cnt_i) and the layer's MAC/ReLU/temp-buffer datapath.

Parameters:
IN_LEN, 64, MAC cycles per pass (≥2)
NUM_PASS, 2, output-group passes per frame (≥1)
X_AW, 6, activation address width (2^X_AW ≥ IN_LEN)
W_AW, 7, weight address width (2^W_AW ≥ IN_LEN*NUM_PASS)
RELU_LAT, 2, cycles from last mac_en_o to relu_en_o pulse (≥1)
WR_LAT, 3, cycles from last mac_en_o to temp_wr_en_o pulse (≥1)
SAVE_CYC, 4, drain cycles after last mac_en_o; must exceed max(RELU_LAT, WR_LAT)
CNT_W, 13, width of cnt_i
LAST_CNT, 7879, cnt_i value marking the final frame

Ports:
clk_i  in  1  clock
rstn_i  in  1  reset, asynchronous, active-low
start_i  in  1  frame start; sampled only in IDLE
cnt_i  in  CNT_W  global frame counter
x_addr_o  out  X_AW  activation read address
x_en_o  out  1  activation read enable
w_addr_o  out  W_AW  weight read address
w_en_o  out  1  weight read enable
mac_en_o  out  1  MAC accumulate enable
mac_clear_o  out  1  accumulator clear, coincident with first mac_en_o of a pass
relu_en_o  out  1  ReLU enable pulse
temp_wr_en_o  out  NUM_PASS  one-hot temp-buffer write strobe, bit p for pass p
pass_o  out  clog2(NUM_PASS) or 1  current pass index
busy_o  out  1  high in any state except IDLE and DONE
frame_done_o  out  1  one-cycle pulse at end of every frame
done_o  out  1  one-cycle pulse when final frame completes

Behaviour:
- Reset: every output is 0. The state, pass, counter and delay lines all clear asynchronously, including in the middle of a pass.
- All outputs are registered. Cycle numbering: cycle 0 is the edge where start_i is sampled.
- States: IDLE, RUN, SAVE, NEXT, DONE.
- IDLE: on start_i, set pass=0 and go to RUN. Otherwise stay in IDLE.
- RUN:
  - x_en_o and w_en_o are high for exactly IN_LEN consecutive cycles.
  - Read k of the pass (k = 0..IN_LEN-1): x_addr_o = k, w_addr_o = pass*IN_LEN + k.
  - After the last read, both addresses hold their value and both enables drop.
  - mac_en_o is x_en_o delayed by 1 cycle (buffer read latency). mac_clear_o is high only on the first mac_en_o cycle.
- SAVE:
  - Entered after the final mac_en_o cycle, at cycle L; lasts SAVE_CYC cycles.
  - relu_en_o pulses at L+RELU_LAT.
  - temp_wr_en_o[pass] pulses at L+WR_LAT; every other strobe bit stays 0.
- Pass sequencing:
  - At the end of SAVE with pass < NUM_PASS-1: increment pass and re-enter RUN. The first x_en_o of the new pass is at L+SAVE_CYC+1.
  - Otherwise go to NEXT.
- NEXT (1 cycle): pulse frame_done_o.
  - If cnt_i == LAST_CNT in this cycle, also pulse done_o and go to DONE.
  - Otherwise go to IDLE.
- DONE: all enables are 0 and the state holds until reset.
- start_i is ignored outside IDLE. A start_i in the same cycle as NEXT is not captured.
- Delay lines run every cycle regardless of state, so pulses already launched complete even across a state change.
- Address arithmetic is unsigned; pass*IN_LEN + k never exceeds 2^W_AW - 1 under the parameter constraints.

Optional Feature:
LOCAL_CTRL_FC_GEN_RESTART_EN
- Defined: DONE accepts start_i and behaves exactly like IDLE, so a new image batch can run without reset.
- Undefined: DONE is terminal until rstn_i.

Test Plan:
1. Reset mid-operation: defaults, start at cycle 0, rstn_i low at cycle 30 → all outputs 0 within the same cycle (async). After release, the block sits in IDLE.
2. Single frame, defaults, cnt_i=5:
   - x_en_o high cycles 1..64, x_addr_o 0..63, w_addr_o 0..63.
   - mac_en_o high cycles 2..65; mac_clear_o at 2.
   - relu_en_o at 67; temp_wr_en_o=01 at 68.
3. Second pass, same frame:
   - x_en_o high 70..133, w_addr_o 64..127, x_addr_o 0..63.
   - temp_wr_en_o=10 at 137.
   - frame_done_o at 139, done_o stays 0, then back in IDLE.
4. Final frame: cnt_i=7879 held → done_o and frame_done_o pulse together at 139. A later start_i is ignored; nothing moves and busy_o stays 0.
5. Reparametrised run: NUM_PASS=4, IN_LEN=16, W_AW=6 → w_addr_o ranges 0..15, 16..31, 32..47, 48..63. temp_wr_en_o sequence is 0001, 0010, 0100, 1000.
6. RESTART_EN defined: after case 4, start_i → a new frame runs with timing identical to case 2.
